multicycle_main_control: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath. It sits directly upstream of `ALUControl`, decodes the instruction opcode, and sequences the datapath through fetch, decode, execute, memory and write-back. Each state drives `ALUop`, which `ALUControl` combines with `FieldFunc` to form `ALUConInput`. Memory states stall on a ready handshake, so multi-cycle memory latency is tolerated.

---
 rtl/mips_ctrl_pkg.sv | 47 ++++
 rtl/multicycle_main_control_ctrl_output_decode.sv | 101 ++++++++++
 rtl/multicycle_main_control.sv | 104 ++++++++++
 tb/tb_multicycle_main_control.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM.
// States, opcodes and datapath mux selects live here.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_RTYPE_EX = 4'd3,
    S_RTYPE_WB = 4'd4,
    S_MEMADR   = 4'd5,
    S_MEMRD    = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEMWR    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_main_control_ctrl_output_decode.sv
// Combinational control-word decode for the main control FSM.
// Moore per state; only memory-handshake strobes see mem_ready.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e      state,
  input  logic        mem_ready,
  output logic [1:0]  ALUop,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        instr_done
);

  // Per-state control word; everything idles at 0.
  always_comb begin
    ALUop       = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    PCSrc       = PC_ALU;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    instr_done  = 1'b0;
    unique case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_4;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM4;
      end
      S_RTYPE_EX: begin
        ALUSrcA = 1'b1;
        ALUop   = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSrc       = PC_ALUOUT;
        instr_done  = 1'b1;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDI_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSrc      = PC_JUMP;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Owns state, the opcode latch and the sticky illegal flag.
module multicycle_main_control
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  Opcode,
  input  logic        mem_ready,
  output logic [1:0]  ALUop,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [3:0]  state
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       ill_q, ill_d;
  logic       dec_done;
  logic       bad_op;

  assign bad_op = (state_q == S_DECODE) && !op_legal(Opcode);

  ctrl_output_decode u_dec (
    .state       (state_q),
    .mem_ready   (mem_ready),
    .ALUop       (ALUop),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSrc       (PCSrc),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .instr_done  (dec_done)
  );

  // An undefined opcode ends its instruction in DECODE.
  assign instr_done = dec_done | bad_op;
  assign illegal_op = ill_q;
  assign state      = state_q;

  // State, opcode latch and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 6'd0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
    end
  end

  // Next-state sequencing; Opcode only matters in DECODE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ill_d   = ill_q | bad_op;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = Opcode;
        unique case (Opcode)
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_MEMADR:
        state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEM_WB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_RTYPE_WB, S_MEM_WB, S_BRANCH,
      S_ADDI_WB, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control.
// Stimulus pushes expected control words; a monitor pops and checks.
module tb_multicycle_main_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic [1:0] ALUop, ALUSrcB, PCSrc;
  logic       ALUSrcA, IorD, MemRead, MemWrite, IRWrite;
  logic       PCWrite, PCWriteCond, RegDst, MemtoReg;
  logic       RegWrite, instr_done, illegal_op;
  logic [3:0] state;

  multicycle_main_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Opcode      (Opcode),
    .mem_ready   (mem_ready),
    .ALUop       (ALUop),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSrc       (PCSrc),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       pcw;
    logic       pcwc;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       done;
    logic       ill;
  } cw_t;

  typedef struct {
    cw_t v;
    int  id;
  } item_t;

  item_t q[$];
  event  chk;
  int    total = 0;
  int    bad   = 0;
  int    nid   = 0;
  cw_t   got;

  assign got = '{state, ALUop, ALUSrcA, ALUSrcB, PCSrc,
                 IorD, MemRead, MemWrite, IRWrite, PCWrite,
                 PCWriteCond, RegDst, MemtoReg, RegWrite,
                 instr_done, illegal_op};

  // Expected control word, written out from the state table.
  function automatic cw_t expw(state_e s, logic mr,
                               logic ill, logic idone);
    cw_t e;
    e = '0;
    e.st  = s;
    e.ill = ill;
    case (s)
      S_FETCH: begin
        e.mrd = 1; e.srcb = 2'b01;
        e.irw = mr; e.pcw = mr;
      end
      S_DECODE: begin
        e.srcb = 2'b11; e.done = idone;
      end
      S_RTYPE_EX: begin
        e.srca = 1; e.aluop = 2'b10;
      end
      S_RTYPE_WB: begin
        e.rdst = 1; e.rw = 1; e.done = 1;
      end
      S_MEMADR: begin
        e.srca = 1; e.srcb = 2'b10;
      end
      S_MEMRD: begin
        e.mrd = 1; e.iord = 1;
      end
      S_MEM_WB: begin
        e.m2r = 1; e.rw = 1; e.done = 1;
      end
      S_MEMWR: begin
        e.mwr = 1; e.iord = 1; e.done = mr;
      end
      S_BRANCH: begin
        e.srca = 1; e.aluop = 2'b01;
        e.pcwc = 1; e.pcsrc = 2'b01; e.done = 1;
      end
      S_ADDI_EX: begin
        e.srca = 1; e.srcb = 2'b10;
      end
      S_ADDI_WB: begin
        e.rw = 1; e.done = 1;
      end
      S_JUMP: begin
        e.pcw = 1; e.pcsrc = 2'b10; e.done = 1;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic push(state_e s, logic mr, logic ill,
                      logic idone);
    item_t it;
    it.v  = expw(s, mr, ill, idone);
    it.id = nid;
    nid++;
    q.push_back(it);
  endtask

  // One clock: drive inputs, queue expectation, advance.
  task automatic cyc(state_e s, logic mr, logic [5:0] op,
                     logic ill, logic idone = 1'b0);
    mem_ready = mr;
    Opcode    = op;
    push(s, mr, ill, idone);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares at negedge or on an async check request.
  initial begin
    item_t it;
    forever begin
      @(negedge clk or chk);
      while (q.size() > 0) begin
        it = q.pop_front();
        total++;
        if (got !== it.v) begin
          bad++;
          $display("FAIL cw#%0d: got=%h want=%h (state %0d/%0d)",
                   it.id, got, it.v, got.st, it.v.st);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    Opcode    = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    cyc(S_IDLE, 1, 6'h00, 0);
    rst_n = 1'b1;
    // R-type, done in cycle 5 after release
    cyc(S_IDLE,     1, 6'h00, 0);
    cyc(S_FETCH,    1, 6'h3F, 0);
    cyc(S_DECODE,   1, 6'h00, 0);
    cyc(S_RTYPE_EX, 1, 6'h3F, 0);
    cyc(S_RTYPE_WB, 1, 6'h23, 0);
    // lw with 3-cycle MEMRD stall
    cyc(S_FETCH,    1, 6'h3F, 0);
    cyc(S_DECODE,   1, 6'h23, 0);
    cyc(S_MEMADR,   1, 6'h2B, 0);
    cyc(S_MEMRD,    0, 6'h2B, 0);
    cyc(S_MEMRD,    0, 6'h00, 0);
    cyc(S_MEMRD,    0, 6'h3F, 0);
    cyc(S_MEMRD,    1, 6'h00, 0);
    cyc(S_MEM_WB,   1, 6'h00, 0);
    // sw with one MEMWR stall
    cyc(S_FETCH,    1, 6'h00, 0);
    cyc(S_DECODE,   1, 6'h2B, 0);
    cyc(S_MEMADR,   1, 6'h23, 0);
    cyc(S_MEMWR,    0, 6'h23, 0);
    cyc(S_MEMWR,    1, 6'h00, 0);
    // beq
    cyc(S_FETCH,    1, 6'h00, 0);
    cyc(S_DECODE,   1, 6'h04, 0);
    cyc(S_BRANCH,   1, 6'h08, 0);
    // addi
    cyc(S_FETCH,    1, 6'h00, 0);
    cyc(S_DECODE,   1, 6'h08, 0);
    cyc(S_ADDI_EX,  1, 6'h3F, 0);
    cyc(S_ADDI_WB,  1, 6'h3F, 0);
    // j
    cyc(S_FETCH,    1, 6'h00, 0);
    cyc(S_DECODE,   1, 6'h02, 0);
    cyc(S_JUMP,     1, 6'h00, 0);
    // illegal opcode, then sticky flag on later R-type
    cyc(S_FETCH,    1, 6'h00, 0);
    cyc(S_DECODE,   1, 6'h3F, 0, 1);
    cyc(S_FETCH,    1, 6'h00, 1);
    cyc(S_DECODE,   1, 6'h00, 1);
    cyc(S_RTYPE_EX, 1, 6'h00, 1);
    cyc(S_RTYPE_WB, 1, 6'h00, 1);
    // FETCH held 5 cycles, then j
    for (int i = 0; i < 5; i++)
      cyc(S_FETCH,  0, 6'h00, 1);
    cyc(S_FETCH,    1, 6'h00, 1);
    cyc(S_DECODE,   1, 6'h02, 1);
    cyc(S_JUMP,     1, 6'h00, 1);
    // sw aborted by reset in MEMWR
    cyc(S_FETCH,    1, 6'h00, 1);
    cyc(S_DECODE,   1, 6'h2B, 1);
    cyc(S_MEMADR,   1, 6'h00, 1);
    mem_ready = 1'b0;
    push(S_MEMWR, 0, 1, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push(S_IDLE, 0, 0, 0);
    ->chk;
    @(posedge clk);
    #1;
    cyc(S_IDLE,     1, 6'h00, 0);
    rst_n = 1'b1;
    cyc(S_IDLE,     1, 6'h00, 0);
    cyc(S_FETCH,    1, 6'h00, 0);
    cyc(S_DECODE,   1, 6'h08, 0);
    cyc(S_ADDI_EX,  1, 6'h00, 0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
